dds_chirp_gen: RTL and testbench

- Parametrised chirp/sweep phase-increment generator in the clk_96 domain; feeds the DDS core's phi_inc_i and an NCO phase word for sin/cos LUTs.
- Adds runtime sweep modes (up, down, triangle, CW), a programmable step count and repeat count, abort, and status flags.
- Configuration is written into shadow registers and copied to the active set only when a sweep is armed, so a running chirp is never corrupted.

---
 rtl/dds_chirp_pkg.sv | 23 ++
 rtl/dds_chirp_gen_phase_acc.sv | 37 +++
 rtl/dds_chirp_gen.sv | 245 ++++++++++++++++++++++++
 tb/tb_dds_chirp_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_chirp_pkg.sv
// Shared types for the chirp generator: sweep modes, controller states and
// the configuration register set used for both the shadow and active copies.
package dds_chirp_pkg;

  // Widest supported configuration; instances may use narrower parameters.
  localparam int CHIRP_ACC_W_MAX  = 48;
  localparam int CHIRP_RATE_W_MAX = 32;
  localparam int CHIRP_CNT_W_MAX  = 16;

  typedef enum logic [1:0] {MODE_UP, MODE_DOWN, MODE_TRI, MODE_CW} chirp_mode_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} chirp_state_t;

  typedef struct packed {
    logic [CHIRP_ACC_W_MAX-1:0]  freq;
    logic [CHIRP_ACC_W_MAX-1:0]  step;
    logic [CHIRP_RATE_W_MAX-1:0] rate;
    logic [CHIRP_CNT_W_MAX-1:0]  nsteps;
    logic [CHIRP_CNT_W_MAX-1:0]  nrep;
    chirp_mode_t                 mode;
  } chirp_cfg_t;

endpackage

// File: rtl/dds_chirp_gen_phase_acc.sv
// Phase accumulator with synchronous clear and enable; exposes the top
// PHO_W bits of the accumulator as the NCO phase word.
module dds_phase_acc #(
  parameter int ACC_W = 48,
  parameter int PHO_W = 16
) (
  input  logic             clk_96,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic [PHO_W-1:0] phase
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + inc;
    end
  end

  always_ff @(posedge clk_96 or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign phase = acc_q[ACC_W-1 -: PHO_W];

endmodule

// File: rtl/dds_chirp_gen.sv
// Chirp/sweep phase-increment generator: up, down, triangle and CW sweeps with
// step timing, repeat count and abort. Configuration is shadowed until armed.
module dds_chirp_gen
  import dds_chirp_pkg::*;
#(
  parameter int ACC_W  = 48,
  parameter int RATE_W = 32,
  parameter int CNT_W  = 16,
  parameter int PHO_W  = 16
) (
  input  logic              clk_96,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [ACC_W-1:0]  cfg_freq,
  input  logic [ACC_W-1:0]  cfg_step,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic [CNT_W-1:0]  cfg_nsteps,
  input  logic [CNT_W-1:0]  cfg_nrep,
  input  logic [1:0]        cfg_mode,
  input  logic              start,
  input  logic              abort,
  output logic [ACC_W-1:0]  phi_inc,
  output logic [PHO_W-1:0]  phase,
  output logic              valid,
  output logic              sof,
  output logic              busy,
  output logic              done
);

  chirp_state_t      state_q, state_d;
  chirp_cfg_t        shadow_q, shadow_d;
  chirp_cfg_t        active_q, active_d;
  chirp_cfg_t        cfg_in;
  logic              start_dly_q;
  logic [ACC_W-1:0]  phi_inc_q, phi_inc_d;
  logic [RATE_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  logic              dir_q, dir_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              start_edge;
  logic              acc_clr;
  logic              acc_en;
  logic [ACC_W-1:0]  f0;
  logic [ACC_W-1:0]  stp;
  logic [RATE_W-1:0] rate;
  logic [CNT_W-1:0]  n_steps;
  logic [CNT_W-1:0]  n_rep;
  logic              leg_end;
  logic              sweep_end;
  logic              tri_flip;
  logic              last_rep;

  assign start_edge = start & ~start_dly_q;

  assign f0      = active_q.freq[ACC_W-1:0];
  assign stp     = active_q.step[ACC_W-1:0];
  assign rate    = active_q.rate[RATE_W-1:0];
  assign n_steps = active_q.nsteps[CNT_W-1:0];
  assign n_rep   = active_q.nrep[CNT_W-1:0];

  always_comb begin
    cfg_in        = '0;
    cfg_in.freq   = CHIRP_ACC_W_MAX'(cfg_freq);
    cfg_in.step   = CHIRP_ACC_W_MAX'(cfg_step);
    cfg_in.rate   = CHIRP_RATE_W_MAX'(cfg_rate);
    cfg_in.nsteps = CHIRP_CNT_W_MAX'(cfg_nsteps);
    cfg_in.nrep   = CHIRP_CNT_W_MAX'(cfg_nrep);
    cfg_in.mode   = chirp_mode_t'(cfg_mode);
  end

  // A triangle runs its up leg until the counter hits N, then restarts the
  // count at 1 so the flip step itself is the first step of the down leg.
  always_comb begin
    leg_end   = (step_cnt_q == n_steps);
    sweep_end = 1'b0;
    tri_flip  = 1'b0;
    if (n_steps == '0) begin
      sweep_end = 1'b1;
    end else if (active_q.mode == MODE_TRI) begin
      sweep_end = leg_end & dir_q;
      tri_flip  = leg_end & ~dir_q;
    end else begin
      sweep_end = leg_end;
    end
    last_rep = (n_rep != '0) && ((rep_q + CNT_W'(1)) == n_rep);
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = cfg_wr ? cfg_in : shadow_q;
    active_d   = active_q;
    phi_inc_d  = phi_inc_q;
    timer_d    = timer_q;
    step_cnt_d = step_cnt_q;
    rep_d      = rep_q;
    dir_d      = dir_q;
    valid_d    = valid_q;
    sof_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        acc_clr = 1'b1;
        if (start_edge && !abort) begin
          active_d   = shadow_d;
          phi_inc_d  = shadow_d.freq[ACC_W-1:0];
          timer_d    = '0;
          step_cnt_d = '0;
          rep_d      = '0;
          dir_d      = (shadow_d.mode == MODE_DOWN);
          state_d    = ST_RUN;
          valid_d    = 1'b1;
          sof_d      = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end

      ST_RUN: begin
        if (abort || !start) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          phi_inc_d = '0;
          acc_clr   = 1'b1;
        end else begin
          acc_en = 1'b1;
          if (timer_q == rate) begin
            timer_d = '0;
            if (sweep_end) begin
              if (last_rep) begin
                state_d = ST_DONE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                rep_d      = rep_q + CNT_W'(1);
                step_cnt_d = '0;
                phi_inc_d  = f0;
                dir_d      = (active_q.mode == MODE_DOWN);
                sof_d      = 1'b1;
              end
            end else if (tri_flip) begin
              dir_d      = 1'b1;
              step_cnt_d = CNT_W'(1);
              phi_inc_d  = phi_inc_q - stp;
            end else begin
              step_cnt_d = step_cnt_q + CNT_W'(1);
              if (active_q.mode == MODE_CW) begin
                phi_inc_d = f0;
              end else if (dir_q) begin
                phi_inc_d = phi_inc_q - stp;
              end else begin
                phi_inc_d = phi_inc_q + stp;
              end
            end
          end else begin
            timer_d = timer_q + RATE_W'(1);
          end
        end
      end

      ST_DONE: begin
        if (abort || !start) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          phi_inc_d = '0;
          acc_clr   = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        phi_inc_d = '0;
        acc_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_96 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      active_q    <= '0;
      start_dly_q <= 1'b0;
      phi_inc_q   <= '0;
      timer_q     <= '0;
      step_cnt_q  <= '0;
      rep_q       <= '0;
      dir_q       <= 1'b0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      start_dly_q <= start;
      phi_inc_q   <= phi_inc_d;
      timer_q     <= timer_d;
      step_cnt_q  <= step_cnt_d;
      rep_q       <= rep_d;
      dir_q       <= dir_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The accumulator adds the increment that is on the output this cycle.
  dds_phase_acc #(
    .ACC_W(ACC_W),
    .PHO_W(PHO_W)
  ) u_phase_acc (
    .clk_96(clk_96),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .inc   (phi_inc_q),
    .phase (phase)
  );

  assign phi_inc = phi_inc_q;
  assign valid   = valid_q;
  assign sof     = sof_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_dds_chirp_gen.sv
// Directed self-checking bench for dds_chirp_gen: sweep modes, wrap, shadow
// isolation, abort/start-drop, CW phase accumulation and async reset.
module tb_dds_chirp_gen;

  localparam int ACC_W  = 48;
  localparam int RATE_W = 32;
  localparam int CNT_W  = 16;
  localparam int PHO_W  = 16;

  logic              clk_96 = 1'b0;
  logic              rst_n  = 1'b0;
  logic              cfg_wr = 1'b0;
  logic [ACC_W-1:0]  cfg_freq = '0;
  logic [ACC_W-1:0]  cfg_step = '0;
  logic [RATE_W-1:0] cfg_rate = '0;
  logic [CNT_W-1:0]  cfg_nsteps = '0;
  logic [CNT_W-1:0]  cfg_nrep = '0;
  logic [1:0]        cfg_mode = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ACC_W-1:0]  phi_inc;
  logic [PHO_W-1:0]  phase;
  logic              valid;
  logic              sof;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;

  dds_chirp_gen #(
    .ACC_W (ACC_W),
    .RATE_W(RATE_W),
    .CNT_W (CNT_W),
    .PHO_W (PHO_W)
  ) dut (
    .clk_96    (clk_96),
    .rst_n     (rst_n),
    .cfg_wr    (cfg_wr),
    .cfg_freq  (cfg_freq),
    .cfg_step  (cfg_step),
    .cfg_rate  (cfg_rate),
    .cfg_nsteps(cfg_nsteps),
    .cfg_nrep  (cfg_nrep),
    .cfg_mode  (cfg_mode),
    .start     (start),
    .abort     (abort),
    .phi_inc   (phi_inc),
    .phase     (phase),
    .valid     (valid),
    .sof       (sof),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_96 = ~clk_96;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_96);
    #1;
  endtask

  task automatic set_cfg(input logic [47:0] f, s, input logic [31:0] r,
                         input logic [15:0] n, nr, input logic [1:0] m);
    cfg_freq   = f;
    cfg_step   = s;
    cfg_rate   = r;
    cfg_nsteps = n;
    cfg_nrep   = nr;
    cfg_mode   = m;
    cfg_wr     = 1'b1;
    tick();
    cfg_wr     = 1'b0;
  endtask

  task automatic check_sample(input string tag, input logic [47:0] exp_phi, input logic exp_sof);
    check({tag, ".valid"}, 64'(valid), 64'd1);
    check({tag, ".busy"}, 64'(busy), 64'd1);
    check({tag, ".phi"}, 64'(phi_inc), 64'(exp_phi));
    check({tag, ".sof"}, 64'(sof), 64'(exp_sof));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 64'(valid), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".done"}, 64'(done), 64'd0);
    check({tag, ".sof"}, 64'(sof), 64'd0);
    check({tag, ".phi"}, 64'(phi_inc), 64'd0);
    check({tag, ".phase"}, 64'(phase), 64'd0);
  endtask

  initial begin
    logic [47:0] tri_exp [5];
    tri_exp = '{48'h100, 48'h110, 48'h120, 48'h110, 48'h100};

    // Reset state
    #12;
    check_idle("reset");
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");
    $display("[%0t] reset: outputs idle", $time);

    // Mode 0: two up sweeps, four increments of three cycles each
    set_cfg(48'd1000, 48'd10, 32'd2, 16'd3, 16'd2, 2'd0);
    start = 1'b1;
    tick();
    for (int k = 0; k < 24; k++) begin
      check_sample($sformatf("up_s%0d", k), 48'(1000 + 10 * ((k % 12) / 3)), (k % 12) == 0);
      tick();
    end
    check("up_done.done", 64'(done), 64'd1);
    check("up_done.valid", 64'(valid), 64'd0);
    check("up_done.busy", 64'(busy), 64'd0);
    check("up_done.phi_held", 64'(phi_inc), 64'd1030);
    tick();
    check("up_hold.done", 64'(done), 64'd1);
    check("up_hold.valid", 64'(valid), 64'd0);
    start = 1'b0;
    tick();
    check_idle("up_release");
    $display("[%0t] mode0 up sweep x2: 24 samples then done", $time);

    // Mode 2: single triangle, no overshoot below F0
    set_cfg(48'h100, 48'h10, 32'd0, 16'd2, 16'd1, 2'd2);
    start = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check_sample($sformatf("tri_s%0d", k), tri_exp[k], k == 0);
      tick();
    end
    check("tri_done.done", 64'(done), 64'd1);
    check("tri_done.valid", 64'(valid), 64'd0);
    check("tri_done.phi_held", 64'(phi_inc), 64'h100);
    start = 1'b0;
    tick();
    check_idle("tri_release");
    $display("[%0t] mode2 triangle: 5 samples then done", $time);

    // Mode 1 wrap below zero, infinite repeats
    set_cfg(48'd5, 48'd10, 32'd0, 16'd1, 16'd0, 2'd1);
    start = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      check_sample($sformatf("wrap_s%0d", k), (k % 2 == 0) ? 48'd5 : 48'hFFFF_FFFF_FFFB, (k % 2) == 0);
      check($sformatf("wrap_s%0d.phase", k), 64'(phase), 64'd0);
      tick();
    end
    start = 1'b0;
    tick();
    check_idle("wrap_release");
    $display("[%0t] mode1 wrap: 8 samples alternating", $time);

    // Shadow isolation: new F0 written mid-run applies only on re-arm
    set_cfg(48'd1000, 48'd10, 32'd0, 16'd1, 16'd0, 2'd0);
    start = 1'b1;
    tick();
    check_sample("shadow_s0", 48'd1000, 1'b1);
    cfg_freq = 48'd5000;
    cfg_wr   = 1'b1;
    tick();
    cfg_wr   = 1'b0;
    check_sample("shadow_s1", 48'd1010, 1'b0);
    tick();
    check_sample("shadow_s2", 48'd1000, 1'b1);
    tick();
    check_sample("shadow_s3", 48'd1010, 1'b0);
    tick();
    check_sample("shadow_s4", 48'd1000, 1'b1);
    start = 1'b0;
    tick();
    check_idle("shadow_drop");
    start = 1'b1;
    tick();
    check_sample("shadow_rearm_s0", 48'd5000, 1'b1);
    tick();
    check_sample("shadow_rearm_s1", 48'd5010, 1'b0);
    start = 1'b0;
    tick();
    $display("[%0t] shadow isolation: reload 1000, rearm 5000", $time);

    // Abort mid-step with start held high, then start-drop mid-step
    set_cfg(48'd1000, 48'd10, 32'd100, 16'd3, 16'd0, 2'd0);
    start = 1'b1;
    tick();
    repeat (5) tick();
    check_sample("abort_pre", 48'd1000, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_post");
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort_norestart%0d.valid", k), 64'(valid), 64'd0);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check_sample("abort_rearm", 48'd1000, 1'b1);
    repeat (5) tick();
    start = 1'b0;
    tick();
    check_idle("startdrop_post");
    start = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_with_edge");
    tick();
    check("abort_with_edge_next.valid", 64'(valid), 64'd0);
    start = 1'b0;
    tick();
    $display("[%0t] abort and start-drop: no restart without new edge", $time);

    // CW with N=0: sof every sample, phase steps by 1 in the top bits
    set_cfg(48'h0001_0000_0000, 48'd7, 32'd0, 16'd0, 16'd3, 2'd3);
    start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      check_sample($sformatf("cw_s%0d", k), 48'h0001_0000_0000, 1'b1);
      check($sformatf("cw_s%0d.phase", k), 64'(phase), 64'(k));
      tick();
    end
    check("cw_done.done", 64'(done), 64'd1);
    check("cw_done.phase", 64'(phase), 64'd3);
    tick();
    check("cw_frozen.phase", 64'(phase), 64'd3);
    check("cw_frozen.phi", 64'(phi_inc), 64'h0001_0000_0000);
    start = 1'b0;
    tick();
    check_idle("cw_release");
    $display("[%0t] mode3 CW: 3 sweeps, phase frozen at 3", $time);

    // Asynchronous reset between clock edges
    set_cfg(48'h0001_0000_0000, 48'd0, 32'd0, 16'd0, 16'd0, 2'd3);
    start = 1'b1;
    tick();
    tick();
    tick();
    check("areset_pre.phase", 64'(phase), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("areset_during");
    start = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check_idle("areset_released");
    start = 1'b1;
    tick();
    check_sample("areset_cleared_cfg", 48'd0, 1'b1);
    start = 1'b0;
    tick();
    set_cfg(48'h0001_0000_0000, 48'd0, 32'd0, 16'd0, 16'd0, 2'd3);
    start = 1'b1;
    tick();
    check_sample("areset_rearm_s0", 48'h0001_0000_0000, 1'b1);
    check("areset_rearm_s0.phase", 64'(phase), 64'd0);
    tick();
    check("areset_rearm_s1.phase", 64'(phase), 64'd1);
    start = 1'b0;
    tick();
    $display("[%0t] async reset: cleared mid-cycle, clean restart", $time);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
